// File: rtl/imm_decode_stage.sv
// Registered LEGv8 immediate decode stage feeding the sign extender, with a 2-entry skid buffer.
// Optional feature: define IMM_DECODE_ILLEGAL_EN to flag unmatched opcodes on Illegal.
module imm_decode_stage #(
    parameter int PC_W = 64
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            InValid,
    output logic            InReady,
    input  logic [31:0]     InInstr,
    input  logic [PC_W-1:0] InPC,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [PC_W-1:0] OutPC,
    output logic [25:0]     Imm,
    output logic [2:0]      SignOp,
    output logic            ImmUsed,
    output logic [4:0]      Rd,
    output logic            Illegal
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [25:0]     imm;
        logic [2:0]      sign_op;
        logic            imm_used;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    // Returns {illegal, imm_used, sign_op}; casez order gives first-match priority.
    function automatic logic [4:0] decode_ctrl(input logic [10:0] op);
        logic [4:0] ctrl;
        casez (op)
            11'b000101?????: ctrl = {1'b0, 1'b1, 3'b010};
            11'b1011010????: ctrl = {1'b0, 1'b1, 3'b011};
            11'b11111000010,
            11'b11111000000: ctrl = {1'b0, 1'b1, 3'b001};
            11'b1001000100?,
            11'b1101000100?,
            11'b1001001000?,
            11'b1011001000?: ctrl = {1'b0, 1'b1, 3'b000};
            11'b110100101??: ctrl = {1'b0, 1'b1, 1'b1, op[1:0]};
            11'b10001011000,
            11'b11001011000,
            11'b10001010000,
            11'b10101010000: ctrl = {1'b0, 1'b0, 3'b000};
`ifdef IMM_DECODE_ILLEGAL_EN
            default:         ctrl = {1'b1, 1'b0, 3'b000};
`else
            default:         ctrl = {1'b0, 1'b0, 3'b000};
`endif
        endcase
        return ctrl;
    endfunction

    entry_t     head_r;
    entry_t     skid_r;
    entry_t     in_entry_s;
    logic       head_valid_r;
    logic       skid_valid_r;
    logic       in_ready_r;
    logic       in_fire_s;
    logic       out_fire_s;
    logic       head_load_s;
    logic       head_valid_n_s;
    logic       skid_valid_n_s;
    logic [4:0] ctrl_s;

    // Decode the incoming word and derive handshake/occupancy next state.
    always_comb begin
        ctrl_s              = decode_ctrl(InInstr[31:21]);
        in_entry_s.pc       = InPC;
        in_entry_s.imm      = InInstr[25:0];
        in_entry_s.sign_op  = ctrl_s[2:0];
        in_entry_s.imm_used = ctrl_s[3];
        in_entry_s.rd       = InInstr[4:0];
        in_entry_s.illegal  = ctrl_s[4];
        in_fire_s           = InValid & in_ready_r;
        out_fire_s          = head_valid_r & OutReady;
        head_load_s         = ~head_valid_r | out_fire_s;
        if (head_load_s) begin
            if (skid_valid_r) begin
                head_valid_n_s = 1'b1;
                skid_valid_n_s = in_fire_s;
            end else begin
                head_valid_n_s = in_fire_s;
                skid_valid_n_s = 1'b0;
            end
        end else begin
            head_valid_n_s = 1'b1;
            skid_valid_n_s = skid_valid_r | in_fire_s;
        end
    end

    // Head/skid storage; the head only changes when empty or being consumed.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            head_r       <= '0;
            skid_r       <= '0;
            head_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            head_valid_r <= head_valid_n_s;
            skid_valid_r <= skid_valid_n_s;
            in_ready_r   <= ~skid_valid_n_s;
            if (head_load_s) begin
                if (skid_valid_r) begin
                    head_r <= skid_r;
                    if (in_fire_s) begin
                        skid_r <= in_entry_s;
                    end
                end else if (in_fire_s) begin
                    head_r <= in_entry_s;
                end
            end else if (in_fire_s) begin
                skid_r <= in_entry_s;
            end
        end
    end

    assign InReady  = in_ready_r;
    assign OutValid = head_valid_r;
    assign OutPC    = head_r.pc;
    assign Imm      = head_r.imm;
    assign SignOp   = head_r.sign_op;
    assign ImmUsed  = head_r.imm_used;
    assign Rd       = head_r.rd;
    assign Illegal  = head_r.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: occupancy/order model plus directed literal checks.
module tb_imm_decode_stage;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] InInstr = 32'h0;
    logic [63:0] InPC = 64'h0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [63:0] OutPC;
    logic [25:0] Imm;
    logic [2:0]  SignOp;
    logic        ImmUsed;
    logic [4:0]  Rd;
    logic        Illegal;

    int total = 0;
    int bad = 0;

`ifdef IMM_DECODE_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    imm_decode_stage #(.PC_W(64)) dut (
        .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InInstr(InInstr), .InPC(InPC), .OutValid(OutValid), .OutReady(OutReady),
        .OutPC(OutPC), .Imm(Imm), .SignOp(SignOp), .ImmUsed(ImmUsed), .Rd(Rd),
        .Illegal(Illegal)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] sop;
        logic       used;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } txn_t;

    txn_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction classification written straight from the opcode table.
    function automatic exp_t model(input logic [31:0] w);
        exp_t e;
        logic [10:0] op11;
        op11 = w[31:21];
        e = '{sop: 3'd0, used: 1'b0, ill: 1'b0};
        if (w[31:26] == 6'b000101) begin
            e.sop = 3'd2; e.used = 1'b1;
        end else if (w[31:25] == 7'b1011010) begin
            e.sop = 3'd3; e.used = 1'b1;
        end else if (op11 == 11'h7C2 || op11 == 11'h7C0) begin
            e.sop = 3'd1; e.used = 1'b1;
        end else if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100 ||
                     w[31:22] == 10'b1001001000 || w[31:22] == 10'b1011001000) begin
            e.sop = 3'd0; e.used = 1'b1;
        end else if (w[31:23] == 9'b110100101) begin
            e.sop = 3'd4 + {1'b0, w[22:21]}; e.used = 1'b1;
        end else if (op11 == 11'b10001011000 || op11 == 11'b11001011000 ||
                     op11 == 11'b10001010000 || op11 == 11'b10101010000) begin
            e.sop = 3'd0; e.used = 1'b0;
        end else begin
            e.ill = ILL_EN;
        end
        return e;
    endfunction

    // Compare process: every negedge check outputs against the queue model, then advance it.
    always @(negedge CLK) begin
        exp_t e;
        logic in_f, out_f;
        if (Reset) begin
            q.delete();
        end else begin
            chk("out_valid", 64'(OutValid), 64'(q.size() > 0));
            chk("in_ready", 64'(InReady), 64'(q.size() < 2));
            if (OutValid && q.size() > 0) begin
                e = model(q[0].instr);
                chk("out_pc", OutPC, q[0].pc);
                chk("imm", 64'(Imm), 64'(q[0].instr[25:0]));
                chk("rd", 64'(Rd), 64'(q[0].instr[4:0]));
                chk("sign_op", 64'(SignOp), 64'(e.sop));
                chk("imm_used", 64'(ImmUsed), 64'(e.used));
                chk("illegal", 64'(Illegal), 64'(e.ill));
            end
            out_f = OutValid & OutReady;
            in_f  = InValid & InReady;
            if (out_f && q.size() > 0) void'(q.pop_front());
            if (in_f) q.push_back('{instr: InInstr, pc: InPC});
        end
    end

    // Present one word and hold it until accepted, with a bounded wait.
    task automatic send(input logic [31:0] w, input logic [63:0] pc);
        logic acc;
        acc = 1'b0;
        InValid = 1'b1; InInstr = w; InPC = pc;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge CLK);
            acc = InReady;
            @(posedge CLK); #1;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    logic [31:0] strm [4] = '{32'h17FFFFFF, 32'hB4000085, 32'hF8408083, 32'hD2B7DDE0};
    logic [2:0]  strm_sop [4] = '{3'b010, 3'b011, 3'b001, 3'b101};
    logic [4:0]  strm_rd [4] = '{5'd31, 5'd5, 5'd3, 5'd0};

    initial begin
        int cnt;
        exp_t m;
        // pin the model with hand-decoded words
        m = model(32'hD2B7DDE0); chk("model_movz", 64'(m.sop), 64'd5);
        m = model(32'h17FFFFFF); chk("model_b", 64'(m.sop), 64'd2);
        m = model(32'h91001441); chk("model_addi_used", 64'(m.used), 64'd1);
        m = model(32'h8B000000); chk("model_add_used", 64'(m.used), 64'd0);

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_valid", 64'(OutValid), 64'd0);
        chk("rst_in_ready", 64'(InReady), 64'd1);
        chk("rst_imm", 64'(Imm), 64'd0);
        chk("rst_sign_op", 64'(SignOp), 64'd0);
        chk("rst_pc", OutPC, 64'd0);
        chk("rst_illegal", 64'(Illegal), 64'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;

        // ADDI single transfer
        OutReady = 1'b1;
        send(32'h91001441, 64'h100);
        InValid = 1'b0;
        @(negedge CLK);
        chk("addi_valid", 64'(OutValid), 64'd1);
        chk("addi_sign_op", 64'(SignOp), 64'd0);
        chk("addi_used", 64'(ImmUsed), 64'd1);
        chk("addi_imm", 64'(Imm), 64'h1001441);
        chk("addi_rd", 64'(Rd), 64'd1);
        chk("addi_pc", OutPC, 64'h100);

        // back-to-back stream of immediate forms
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            InValid = 1'b1; InInstr = strm[i]; InPC = 64'h200 + 64'(4 * i);
            @(negedge CLK);
            if (i > 0) begin
                chk("strm_sign_op", 64'(SignOp), 64'(strm_sop[i-1]));
                chk("strm_rd", 64'(Rd), 64'(strm_rd[i-1]));
            end
        end
        @(posedge CLK); #1;
        InValid = 1'b0;
        @(negedge CLK);
        chk("strm_sign_op_last", 64'(SignOp), 64'(strm_sop[3]));
        chk("strm_rd_last", 64'(Rd), 64'(strm_rd[3]));

        // backpressure: fill head and skid, then stall the third word
        @(posedge CLK); #1;
        OutReady = 1'b0;
        send(32'h91000421, 64'h300);
        send(32'hD1000842, 64'h304);
        InValid = 1'b1; InInstr = 32'h8B020023; InPC = 64'h308;
        repeat (3) begin
            @(negedge CLK);
            chk("bp_in_ready", 64'(InReady), 64'd0);
            chk("bp_hold_pc", OutPC, 64'h300);
        end
        @(posedge CLK); #1;
        OutReady = 1'b1;
        send(32'h8B020023, 64'h308);
        InValid = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // simultaneous accept/emit for 8 words
        cnt = 0;
        @(posedge CLK); #1;
        for (int i = 0; i < 8; i++) begin
            InValid = 1'b1; InInstr = 32'h91000000 + 32'(i * 32'h401); InPC = 64'h400 + 64'(4 * i);
            @(negedge CLK);
            chk("tp_in_ready", 64'(InReady), 64'd1);
            if (i > 0 && OutValid) cnt++;
            @(posedge CLK); #1;
        end
        InValid = 1'b0;
        @(negedge CLK);
        if (OutValid) cnt++;
        chk("tp_outputs", 64'(cnt), 64'd8);

        // unmatched opcode
        @(posedge CLK); #1;
        send(32'h00000000, 64'h500);
        InValid = 1'b0;
        @(negedge CLK);
        chk("zero_valid", 64'(OutValid), 64'd1);
        chk("zero_illegal", 64'(Illegal), 64'(ILL_EN));
        chk("zero_used", 64'(ImmUsed), 64'd0);

        // reset with both entries occupied
        @(posedge CLK); #1;
        OutReady = 1'b0;
        send(32'h17FFFFFF, 64'h600);
        send(32'hB4000085, 64'h604);
        InValid = 1'b0;
        @(posedge CLK); #1;
        Reset = 1'b1;
        @(negedge CLK);
        chk("mrst_out_valid", 64'(OutValid), 64'd0);
        chk("mrst_in_ready", 64'(InReady), 64'd1);
        chk("mrst_imm", 64'(Imm), 64'd0);
        chk("mrst_pc", OutPC, 64'd0);
        chk("mrst_rd", 64'(Rd), 64'd0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        OutReady = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("mrst_no_output", 64'(OutValid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
